// File: rtl/bbox_tracker.sv
// bbox_tracker: per-frame bounding-box tracker for two players.
//   Accumulates min/max x/y and a hit count for each player over a frame,
//   then publishes boxes for players with enough hit pixels.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_enable                 permits tracking (starts at a frame boundary)
//   i_pix_valid, i_x, i_y    pixel stream
//   i_hit[1:0]               per-player classification of the pixel
//   i_frame_end              pulse on the last pixel of a frame
//   o_left/o_right/o_up/o_down[p]  committed box edges per player
//   o_found[p]               player p box valid for last committed frame
//   o_predict_valid          one-cycle pulse when box outputs update

// Per-player accumulator plus committed box registers.
module bbox_lane #(
   parameter int CNT_W     = 20,
   parameter int MIN_COUNT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_take,   // accepted pixel for this player
   input  logic        i_clr,    // commit edge: publish and restart run
   input  logic [10:0] i_x,
   input  logic [10:0] i_y,
   output logic [10:0] o_left,
   output logic [10:0] o_right,
   output logic [10:0] o_up,
   output logic [10:0] o_down,
   output logic        o_found
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_COUNT);

   logic [10:0]      run_l, run_r, run_u, run_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_l   <= 11'h7FF;
         run_r   <= '0;
         run_u   <= 11'h7FF;
         run_d   <= '0;
         cnt     <= '0;
         o_left  <= '0;
         o_right <= '0;
         o_up    <= '0;
         o_down  <= '0;
         o_found <= 1'b0;
      end else if (i_clr) begin
         // Weak frames keep the previous box but drop the found flag.
         if (cnt >= MIN_C) begin
            o_left  <= run_l;
            o_right <= run_r;
            o_up    <= run_u;
            o_down  <= run_d;
            o_found <= 1'b1;
         end else begin
            o_found <= 1'b0;
         end
         // Restart from init, seeded by a pixel of the next frame if present.
         if (i_take) begin
            run_l <= i_x;
            run_r <= i_x;
            run_u <= i_y;
            run_d <= i_y;
            cnt   <= CNT_W'(1);
         end else begin
            run_l <= 11'h7FF;
            run_r <= '0;
            run_u <= 11'h7FF;
            run_d <= '0;
            cnt   <= '0;
         end
      end else if (i_take) begin
         if (i_x < run_l) run_l <= i_x;
         if (i_x > run_r) run_r <= i_x;
         if (i_y < run_u) run_u <= i_y;
         if (i_y > run_d) run_d <= i_y;
         if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

module bbox_tracker #(
   parameter int          MIN_COUNT = 64,
   parameter logic [10:0] X_MAX     = 11'd799,
   parameter logic [10:0] Y_MAX     = 11'd599,
   parameter int          CNT_W     = 20
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_pix_valid,
   input  logic [10:0]      i_x,
   input  logic [10:0]      i_y,
   input  logic [1:0]       i_hit,
   input  logic             i_frame_end,
   output logic [1:0][10:0] o_left,
   output logic [1:0][10:0] o_right,
   output logic [1:0][10:0] o_up,
   output logic [1:0][10:0] o_down,
   output logic [1:0]       o_found,
   output logic             o_predict_valid
);
   localparam int NUM_LANES = 2;

   typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;
   state_t state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         o_predict_valid <= 1'b0;
      end else begin
         // Pulses in the cycle the committed boxes first become visible.
         o_predict_valid <= (state == COMMIT);
         case (state)
            IDLE:    if (i_frame_end && i_enable) state <= ACCUM;
            ACCUM:   if (i_frame_end) state <= COMMIT;
            COMMIT:  state <= i_enable ? ACCUM : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic pix_ok, take_en, clr;
   logic [NUM_LANES-1:0] take;

   assign pix_ok  = i_pix_valid && (i_x <= X_MAX) && (i_y <= Y_MAX);
   // A pixel seen during COMMIT opens the next frame, but only if tracking
   // continues; otherwise the accumulators must stay at init for IDLE.
   assign take_en = (state == ACCUM) || ((state == COMMIT) && i_enable);
   assign clr     = (state == COMMIT);

   generate
      for (genvar p = 0; p < NUM_LANES; p++) begin : g_lane
         assign take[p] = pix_ok && take_en && i_hit[p];
         bbox_lane #(.CNT_W(CNT_W), .MIN_COUNT(MIN_COUNT)) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_take  (take[p]),
            .i_clr   (clr),
            .i_x     (i_x),
            .i_y     (i_y),
            .o_left  (o_left[p]),
            .o_right (o_right[p]),
            .o_up    (o_up[p]),
            .o_down  (o_down[p]),
            .o_found (o_found[p])
         );
      end
   endgenerate
endmodule
